// File: rtl/idc_pkg.sv
// Shared types and defaults for the round-robin ID-checker scheduler.
package idc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_GAP      = 2'd1,
    ERR_CHK_TO   = 2'd2,
    ERR_START_TO = 2'd3
  } sched_err_t;

  localparam int ID_LEN_DEF = 10;
  localparam int SYM_W_DEF  = 6;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/idc_rr_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after `last`, wrapping.
module rr_arbiter
  import idc_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found_s;
  logic [IW-1:0] cand_s;

  // Scan from last+1 around to last itself; lowest distance wins.
  always_comb begin
    gnt     = {N{1'b0}};
    idx     = {IW{1'b0}};
    found_s = 1'b0;
    cand_s  = {IW{1'b0}};
    for (int i = 1; i <= N; i++) begin
      cand_s = IW'((int'(last) + i) % N);
      if (!found_s && req[cand_s]) begin
        found_s     = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/idc_rr_sched.sv
// Shares one serial ID checker among NUM_REQ requesters: round-robin grant, packet forward,
// verdict wait, tagged response, gap/timeout aborts and saturating legal/illegal tallies.
module idc_rr_sched
  import idc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_LEN  = ID_LEN_DEF,
  parameter int SYM_W   = SYM_W_DEF,
  parameter int TIMEOUT = 32,
  localparam int IDX_W  = $clog2(NUM_REQ),
  localparam int TW     = $clog2(TIMEOUT + 1),
  localparam int CW     = $clog2(ID_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       sym_valid,
  input  logic [NUM_REQ*SYM_W-1:0] sym,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     chk_in_valid,
  output logic [SYM_W-1:0]         chk_in_id,
  input  logic                     chk_out_valid,
  input  logic                     chk_out_legal,
  output logic                     resp_valid,
  output logic [IDX_W-1:0]         resp_src,
  output logic                     resp_legal,
  output logic [1:0]               resp_err,
  output logic                     busy,
  output logic [15:0]              legal_cnt,
  output logic [15:0]              illegal_cnt
);

  sched_state_t         state_r, state_s;
  sched_err_t           resp_err_r, resp_err_s;
  logic [NUM_REQ-1:0]   grant_r, grant_s, arb_gnt_s;
  logic [IDX_W-1:0]     win_r, win_s, ptr_r, ptr_s, arb_idx_s, resp_src_r, resp_src_s;
  logic [TW-1:0]        timer_r, timer_s;
  logic [CW-1:0]        sc_r, sc_s;
  logic                 chk_in_valid_r, chk_in_valid_s, resp_valid_r, resp_valid_s;
  logic                 resp_legal_r, resp_legal_s, sel_valid_s, resp_ok_s;
  logic [SYM_W-1:0]     chk_in_id_r, chk_in_id_s, sel_sym_s;
  logic [15:0]          legal_cnt_r, legal_cnt_s, illegal_cnt_r, illegal_cnt_s;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req  (req),
    .last (ptr_r),
    .gnt  (arb_gnt_s),
    .idx  (arb_idx_s)
  );

  // Mux out the granted requester's symbol lane.
  always_comb begin
    sel_sym_s = {SYM_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_sym_s = sel_sym_s | (sym[i*SYM_W +: SYM_W] & {SYM_W{win_r == IDX_W'(i)}});
    end
    sel_valid_s = sym_valid[win_r] & grant_r[win_r];
  end

  // Next-state and next-output logic; every abort path loads the response fields directly.
  always_comb begin
    state_s        = state_r;
    grant_s        = grant_r;
    win_s          = win_r;
    ptr_s          = ptr_r;
    timer_s        = timer_r;
    sc_s           = sc_r;
    chk_in_valid_s = 1'b0;
    chk_in_id_s    = chk_in_id_r;
    resp_valid_s   = 1'b0;
    resp_src_s     = resp_src_r;
    resp_legal_s   = resp_legal_r;
    resp_err_s     = resp_err_r;
    legal_cnt_s    = legal_cnt_r;
    illegal_cnt_s  = illegal_cnt_r;
    resp_ok_s      = (resp_err_r == ERR_OK);
    case (state_r)
      IDLE: begin
        if (|req) begin
          grant_s = arb_gnt_s;
          win_s   = arb_idx_s;
          timer_s = {TW{1'b0}};
          sc_s    = {CW{1'b0}};
          state_s = STREAM;
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        if (sel_valid_s) begin
          chk_in_valid_s = 1'b1;
          chk_in_id_s    = sel_sym_s;
          if (sc_r == CW'(ID_LEN - 1)) begin
            grant_s = {NUM_REQ{1'b0}};
            timer_s = {TW{1'b0}};
            state_s = WAIT;
          end else begin
            sc_s = sc_r + CW'(1);
          end
        end else if (sc_r != {CW{1'b0}}) begin
          grant_s      = {NUM_REQ{1'b0}};
          resp_valid_s = 1'b1;
          resp_src_s   = win_r;
          resp_legal_s = 1'b0;
          resp_err_s   = ERR_GAP;
          state_s      = RESP;
        end else if (timer_r == TW'(TIMEOUT - 1)) begin
          grant_s      = {NUM_REQ{1'b0}};
          resp_valid_s = 1'b1;
          resp_src_s   = win_r;
          resp_legal_s = 1'b0;
          resp_err_s   = ERR_START_TO;
          state_s      = RESP;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      WAIT: begin
        if (chk_out_valid) begin
          resp_valid_s = 1'b1;
          resp_src_s   = win_r;
          resp_legal_s = chk_out_legal;
          resp_err_s   = ERR_OK;
          state_s      = RESP;
        end else if (timer_r == TW'(TIMEOUT - 1)) begin
          resp_valid_s = 1'b1;
          resp_src_s   = win_r;
          resp_legal_s = 1'b0;
          resp_err_s   = ERR_CHK_TO;
          state_s      = RESP;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      RESP: begin
        ptr_s         = win_r;
        legal_cnt_s   = (resp_ok_s && resp_legal_r)  ? sat_inc16(legal_cnt_r)   : legal_cnt_r;
        illegal_cnt_s = (resp_ok_s && !resp_legal_r) ? sat_inc16(illegal_cnt_r) : illegal_cnt_r;
        state_s       = IDLE;
      end
      default: begin
        grant_s = {NUM_REQ{1'b0}};
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      grant_r        <= {NUM_REQ{1'b0}};
      win_r          <= {IDX_W{1'b0}};
      ptr_r          <= IDX_W'(NUM_REQ - 1);
      timer_r        <= {TW{1'b0}};
      sc_r           <= {CW{1'b0}};
      chk_in_valid_r <= 1'b0;
      chk_in_id_r    <= {SYM_W{1'b0}};
      resp_valid_r   <= 1'b0;
      resp_src_r     <= {IDX_W{1'b0}};
      resp_legal_r   <= 1'b0;
      resp_err_r     <= ERR_OK;
      legal_cnt_r    <= 16'd0;
      illegal_cnt_r  <= 16'd0;
    end else begin
      state_r        <= state_s;
      grant_r        <= grant_s;
      win_r          <= win_s;
      ptr_r          <= ptr_s;
      timer_r        <= timer_s;
      sc_r           <= sc_s;
      chk_in_valid_r <= chk_in_valid_s;
      chk_in_id_r    <= chk_in_id_s;
      resp_valid_r   <= resp_valid_s;
      resp_src_r     <= resp_src_s;
      resp_legal_r   <= resp_legal_s;
      resp_err_r     <= resp_err_s;
      legal_cnt_r    <= legal_cnt_s;
      illegal_cnt_r  <= illegal_cnt_s;
    end
  end

  assign grant        = grant_r;
  assign chk_in_valid = chk_in_valid_r;
  assign chk_in_id    = chk_in_id_r;
  assign resp_valid   = resp_valid_r;
  assign resp_src     = resp_src_r;
  assign resp_legal   = resp_legal_r;
  assign resp_err     = resp_err_r;
  assign busy         = (state_r != IDLE);
  assign legal_cnt    = legal_cnt_r;
  assign illegal_cnt  = illegal_cnt_r;

endmodule

// File: tb/tb_idc_rr_sched.sv
// Directed scenario bench for idc_rr_sched; the bench itself plays requesters and checker.
module tb_idc_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, sym_valid, grant;
  logic [23:0] sym;
  logic        chk_in_valid, chk_out_valid, chk_out_legal;
  logic [5:0]  chk_in_id;
  logic        resp_valid, resp_legal, busy;
  logic [1:0]  resp_src, resp_err;
  logic [15:0] legal_cnt, illegal_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int fwd_n    = 0;
  int gcnt     = 0;
  logic [5:0] fwd_mem [0:255];
  logic [5:0] pkt [0:9];

  idc_rr_sched dut (
    .clk(clk), .rst(rst), .req(req), .sym_valid(sym_valid), .sym(sym),
    .grant(grant), .chk_in_valid(chk_in_valid), .chk_in_id(chk_in_id),
    .chk_out_valid(chk_out_valid), .chk_out_legal(chk_out_legal),
    .resp_valid(resp_valid), .resp_src(resp_src), .resp_legal(resp_legal),
    .resp_err(resp_err), .busy(busy), .legal_cnt(legal_cnt), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  // Record forwarded symbols and granted cycles.
  always @(negedge clk) begin
    if (chk_in_valid && fwd_n < 256) begin
      fwd_mem[fwd_n] <= chk_in_id;
      fwd_n          <= fwd_n + 1;
    end
    if (grant != 4'b0000) gcnt <= gcnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int r, input int n);
    for (int i = 0; i < n; i++) begin
      sym_valid[r]   = 1'b1;
      sym[r*6 +: 6]  = pkt[i];
      tick();
    end
    sym_valid[r] = 1'b0;
  endtask

  task automatic verdict(input int dly, input logic legal);
    repeat (dly) tick();
    chk_out_valid = 1'b1;
    chk_out_legal = legal;
    tick();
    chk_out_valid = 1'b0;
    chk_out_legal = 1'b0;
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (grant != 4'b0000) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_grant: got %b expected 0000", grant); end
    n_checks++; if ({busy, resp_valid, chk_in_valid} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b expected 000", {busy, resp_valid, chk_in_valid}); end
    n_checks++; if ({legal_cnt, illegal_cnt} !== 32'h0) begin n_fail++; $display("FAIL rst_cnt: got %h expected 0", {legal_cnt, illegal_cnt}); end
    n_checks++; if ({resp_src, resp_err, resp_legal} !== 5'b0) begin n_fail++; $display("FAIL rst_resp: got %b expected 0", {resp_src, resp_err, resp_legal}); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_single_legal();
    int g0, base, bad;
    pkt  = '{6'd10, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9};
    g0   = gcnt;
    base = fwd_n;
    req  = 4'b0001;
    tick();
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL t1_grant: got %b expected 0001", grant); end
    req = 4'b0000;
    stream(0, 10);
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL t1_grant_drop: got %b expected 0000", grant); end
    n_checks++; if ({chk_in_valid, chk_in_id} !== {1'b1, 6'd9}) begin n_fail++; $display("FAIL t1_last_fwd: got %b/%0d expected 1/9", chk_in_valid, chk_in_id); end
    verdict(1, 1'b1);
    n_checks++; if ({resp_valid, resp_src, resp_legal, resp_err} !== {1'b1, 2'd0, 1'b1, 2'd0}) begin n_fail++; $display("FAIL t1_resp: got v%b s%0d l%b e%0d expected v1 s0 l1 e0", resp_valid, resp_src, resp_legal, resp_err); end
    tick();
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_pulse: resp_valid got %b expected 0", resp_valid); end
    n_checks++; if (legal_cnt !== 16'd1) begin n_fail++; $display("FAIL t1_legal_cnt: got %0d expected 1", legal_cnt); end
    n_checks++; if (gcnt - g0 !== 10) begin n_fail++; $display("FAIL t1_grant_len: got %0d expected 10", gcnt - g0); end
    n_checks++; if (fwd_n - base !== 10) begin n_fail++; $display("FAIL t1_fwd_len: got %0d expected 10", fwd_n - base); end
    bad = 0;
    for (int i = 0; i < 10; i++) if (fwd_mem[base + i] !== pkt[i]) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL t1_fwd_data: got %0d wrong symbols expected 0", bad); end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    pkt = '{6'd10, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9};
    for (int k = 0; k < 5; k++) begin
      eg  = 4'b0001 << (k % 4);
      req = 4'b1111;
      wait_grant();
      n_checks++; if (grant !== eg) begin n_fail++; $display("FAIL t2_grant%0d: got %b expected %b", k, grant, eg); end
      stream(k % 4, 10);
      verdict(0, 1'b1);
      n_checks++; if ({resp_valid, resp_src} !== {1'b1, 2'(k % 4)}) begin n_fail++; $display("FAIL t2_src%0d: got v%b s%0d expected v1 s%0d", k, resp_valid, resp_src, k % 4); end
    end
    req = 4'b0000;
    tick();
    n_checks++; if (legal_cnt !== 16'd5) begin n_fail++; $display("FAIL t2_legal_cnt: got %0d expected 5", legal_cnt); end
  endtask

  task automatic test_gap();
    req = 4'b0100;
    wait_grant();
    req = 4'b0000;
    n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL t3_grant: got %b expected 0100", grant); end
    stream(2, 5);
    n_checks++; if (chk_in_valid !== 1'b1) begin n_fail++; $display("FAIL t3_fifth_fwd: got %b expected 1", chk_in_valid); end
    tick();
    n_checks++; if (chk_in_valid !== 1'b0) begin n_fail++; $display("FAIL t3_fwd_drop: got %b expected 0", chk_in_valid); end
    n_checks++; if ({resp_valid, resp_src, resp_legal, resp_err, grant} !== {1'b1, 2'd2, 1'b0, 2'd1, 4'b0000}) begin n_fail++; $display("FAIL t3_resp: got v%b s%0d l%b e%0d g%b expected v1 s2 l0 e1 g0000", resp_valid, resp_src, resp_legal, resp_err, grant); end
    tick();
    n_checks++; if ({legal_cnt, illegal_cnt} !== {16'd5, 16'd0}) begin n_fail++; $display("FAIL t3_cnt: got %0d/%0d expected 5/0", legal_cnt, illegal_cnt); end
  endtask

  task automatic test_timeouts();
    int f0;
    f0  = fwd_n;
    req = 4'b0010;
    wait_grant();
    req = 4'b0000;
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL t4_grant: got %b expected 0010", grant); end
    repeat (31) tick();
    n_checks++; if ({resp_valid, grant} !== {1'b0, 4'b0010}) begin n_fail++; $display("FAIL t4_start_early: got v%b g%b expected v0 g0010", resp_valid, grant); end
    tick();
    n_checks++; if ({resp_valid, resp_src, resp_legal, resp_err} !== {1'b1, 2'd1, 1'b0, 2'd3}) begin n_fail++; $display("FAIL t4_start_to: got v%b s%0d l%b e%0d expected v1 s1 l0 e3", resp_valid, resp_src, resp_legal, resp_err); end
    n_checks++; if (fwd_n !== f0) begin n_fail++; $display("FAIL t4_no_fwd: got %0d symbols expected 0", fwd_n - f0); end
    pkt = '{6'd10, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9};
    req = 4'b0010;
    wait_grant();
    req = 4'b0000;
    stream(1, 10);
    repeat (31) tick();
    n_checks++; if ({resp_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL t4_chk_early: got v%b b%b expected v0 b1", resp_valid, busy); end
    tick();
    n_checks++; if ({resp_valid, resp_src, resp_legal, resp_err} !== {1'b1, 2'd1, 1'b0, 2'd2}) begin n_fail++; $display("FAIL t4_chk_to: got v%b s%0d l%b e%0d expected v1 s1 l0 e2", resp_valid, resp_src, resp_legal, resp_err); end
    tick();
    chk_out_valid = 1'b1;
    chk_out_legal = 1'b1;
    tick();
    chk_out_valid = 1'b0;
    chk_out_legal = 1'b0;
    tick();
    n_checks++; if ({resp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL t4_stray_verdict: got v%b b%b expected v0 b0", resp_valid, busy); end
    n_checks++; if ({legal_cnt, illegal_cnt} !== {16'd5, 16'd0}) begin n_fail++; $display("FAIL t4_cnt: got %0d/%0d expected 5/0", legal_cnt, illegal_cnt); end
  endtask

  task automatic test_reset_mid();
    pkt = '{6'd10, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9};
    req = 4'b0001;
    wait_grant();
    req = 4'b0000;
    stream(0, 10);
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if ({grant, resp_valid, busy, chk_in_valid} !== 7'b0) begin n_fail++; $display("FAIL t5_rst_now: got g%b v%b b%b c%b expected all 0", grant, resp_valid, busy, chk_in_valid); end
    n_checks++; if ({legal_cnt, illegal_cnt} !== 32'h0) begin n_fail++; $display("FAIL t5_rst_cnt: got %0d/%0d expected 0/0", legal_cnt, illegal_cnt); end
    rst           = 1'b0;
    chk_out_valid = 1'b1;
    chk_out_legal = 1'b1;
    tick();
    chk_out_valid = 1'b0;
    chk_out_legal = 1'b0;
    tick();
    n_checks++; if ({resp_valid, busy, legal_cnt} !== 18'b0) begin n_fail++; $display("FAIL t5_late_verdict: got v%b b%b c%0d expected v0 b0 c0", resp_valid, busy, legal_cnt); end
  endtask

  task automatic test_saturate();
    logic [15:0] exp_cnt [0:2];
    exp_cnt = '{16'hFFFE, 16'hFFFF, 16'hFFFF};
    pkt     = '{6'd10, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd8};
    force dut.illegal_cnt_r = 16'hFFFD;
    tick();
    release dut.illegal_cnt_r;
    tick();
    n_checks++; if (illegal_cnt !== 16'hFFFD) begin n_fail++; $display("FAIL t6_preload: got %h expected fffd", illegal_cnt); end
    for (int k = 0; k < 3; k++) begin
      req = 4'b1000;
      wait_grant();
      req = 4'b0000;
      stream(3, 10);
      verdict(2, 1'b0);
      n_checks++; if ({resp_valid, resp_src, resp_legal, resp_err} !== {1'b1, 2'd3, 1'b0, 2'd0}) begin n_fail++; $display("FAIL t6_resp%0d: got v%b s%0d l%b e%0d expected v1 s3 l0 e0", k, resp_valid, resp_src, resp_legal, resp_err); end
      tick();
      n_checks++; if (illegal_cnt !== exp_cnt[k]) begin n_fail++; $display("FAIL t6_sat%0d: got %h expected %h", k, illegal_cnt, exp_cnt[k]); end
    end
    n_checks++; if (legal_cnt !== 16'd0) begin n_fail++; $display("FAIL t6_legal_cnt: got %0d expected 0", legal_cnt); end
  endtask

  initial begin
    rst           = 1'b1;
    req           = 4'b0000;
    sym_valid     = 4'b0000;
    sym           = 24'd0;
    chk_out_valid = 1'b0;
    chk_out_legal = 1'b0;
    test_reset();
    test_single_legal();
    test_round_robin();
    test_gap();
    test_timeouts();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
